// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor controller:
// FSM state encoding and operation select values.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_ctrl_full_adder.sv
// One-bit full adder; the only arithmetic cell of the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    assign s = a ^ b ^ cin;
    assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/sub controller: one full_adder time-shared over WIDTH cycles, LSB first.
// Optional zero flag output enabled by macro SERIAL_ADDSUB_ZFLAG_EN.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the start edge
// RUN   | one operand bit pair processed per cycle
// DONE  | one-cycle completion; result/flags already updated
module serial_addsub_ctrl
    import serial_addsub_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
`ifdef SERIAL_ADDSUB_ZFLAG_EN
    ,
    output logic             zero
`endif
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    // Holds the low WIDTH-1 sum bits; the final sum bit joins them at completion.
    logic [WIDTH-2:0]   r_acc;
    logic               r_carry;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;
    logic               r_ovf;
    logic               w_s;
    logic               w_c;
    logic [WIDTH-2:0]   w_acc_next;

    full_adder u_fa (
        .a   (r_a[0]),
        .b   (r_b[0]),
        .cin (r_carry),
        .s   (w_s),
        .c   (w_c)
    );

    assign w_acc_next = (r_acc >> 1) | ((WIDTH-1)'(w_s) << (WIDTH - 2));

`ifdef SERIAL_ADDSUB_ZFLAG_EN
    logic r_nz;
    logic r_zero;
    assign zero = r_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nz   <= 1'b0;
            r_zero <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_nz <= 1'b0;
        end else if (r_state == RUN) begin
            r_nz <= r_nz | w_s;
            if (r_cnt == LAST_BIT)
                r_zero <= ~(r_nz | w_s);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= op_a;
                        r_b     <= (sub == OP_SUB) ? ~op_b : op_b;
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_acc   <= w_acc_next;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        // r_carry is the carry into the MSB on this edge
                        r_result <= {w_s, r_acc};
                        r_cout   <= w_c;
                        r_ovf    <= r_carry ^ w_c;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: directed cases plus random operations
// against an arithmetic reference model; covers SERIAL_ADDSUB_ZFLAG_EN when defined.
module tb_serial_addsub_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
`ifdef SERIAL_ADDSUB_ZFLAG_EN
    logic             zero;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_done_cyc = -1;
    logic [WIDTH-1:0] prev_res = '0;

    serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
`ifdef SERIAL_ADDSUB_ZFLAG_EN
        ,
        .zero   (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                         output logic [WIDTH-1:0] r, output logic co, output logic ov);
        longint ua, ub, full, sa, sb, sres;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            full = ua + (longint'(1) << WIDTH) - ub;
            sres = sa - sb;
        end else begin
            full = ua + ub;
            sres = sa + sb;
        end
        r  = WIDTH'(full);
        co = (full >= (longint'(1) << WIDTH));
        ov = (sres > ((longint'(1) << (WIDTH-1)) - 1)) || (sres < -(longint'(1) << (WIDTH-1)));
    endtask

    // Called at 1 time unit after a rising edge; returns in the first IDLE cycle after DONE.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                          input bit inject, input bit b2b);
        logic [WIDTH-1:0] er;
        logic eco, eov;
        int ndone, first_k;
        model(a, b, s, er, eco, eov);
        start = 1'b1; op_a = a; op_b = b; sub = s;
        @(posedge clk); #1;
        ndone = 0;
        first_k = -1;
        for (int k = 1; k <= WIDTH + 2; k++) begin
            if (inject && (k == 3 || k == WIDTH + 1)) begin
                start = 1'b1;
                op_a = WIDTH'($urandom);
                op_b = WIDTH'($urandom);
                sub  = 1'($urandom);
            end else begin
                start = 1'b0;
                op_a = WIDTH'($urandom);
                op_b = WIDTH'($urandom);
                sub  = 1'($urandom);
            end
            chk("busy", busy, (k <= WIDTH + 1));
            if (k <= WIDTH) chk("result_held", result, prev_res);
            if (done) begin
                ndone++;
                if (first_k < 0) first_k = k;
                if (b2b && last_done_cyc >= 0) chk("done_spacing", cyc - last_done_cyc, WIDTH + 2);
                last_done_cyc = cyc;
            end
            if (k < WIDTH + 2) begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        chk("done_count", ndone, 1);
        chk("done_latency", first_k, WIDTH + 1);
        chk("result", result, er);
        chk("cout", cout, eco);
        chk("ovf", ovf, eov);
`ifdef SERIAL_ADDSUB_ZFLAG_EN
        chk("zero", zero, (er == '0));
`endif
        prev_res = er;
    endtask

    initial begin
        int gap;
        int ndone;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        run_op(8'h10, 8'h20, 1'b1, 1'b0, 1'b1);
        run_op(8'h80, 8'h01, 1'b1, 1'b0, 1'b1);
        run_op(8'h33, 8'h44, 1'b0, 1'b1, 1'b1);
        run_op(8'h00, 8'h00, 1'b1, 1'b0, 1'b1);

        // Abort mid-run with a one-cycle reset pulse.
        start = 1'b1; op_a = 8'hC3; op_b = 8'h5A; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_cout", cout, 0);
        chk("abort_ovf", ovf, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        repeat (WIDTH + 3) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_result_hold", result, 0);
        prev_res = '0;
        last_done_cyc = -1;
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                   1'($urandom), (gap == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
